// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, four trellis states.
// Saturating normalised path metrics, register survivors and a full-frame traceback.
//
//   state | meaning
//   IDLE  | waiting for a start-of-frame beat; other beats are dropped
//   ACS   | one add-compare-select step per accepted beat
//   TRACE | walk the survivors back from the last step, one bit per cycle
//   OUT   | one-cycle out_valid pulse, then back to IDLE
module viterbi_decoder_k3 #(
   parameter int         FRAME_BITS = 8,
   parameter logic [2:0] G0         = 3'b111,
   parameter logic [2:0] G1         = 3'b101,
   parameter int         METRIC_W   = 5,
   parameter bit         TERMINATED = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [1:0]            in_sym,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [FRAME_BITS-1:0] out_data
);

   localparam int IW = $clog2(FRAME_BITS);
   localparam logic [METRIC_W-1:0] M_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;

   state_t              state;
   logic [IW-1:0]       cnt;
   logic [METRIC_W-1:0] pm [4];
   logic [3:0]          surv [FRAME_BITS];
   logic [1:0]          st;

   logic                accept;
   logic [IW-1:0]       step;
   logic [METRIC_W-1:0] base [4];
   logic [METRIC_W-1:0] raw [4];
   logic [METRIC_W-1:0] norm [4];
   logic [METRIC_W-1:0] mn;
   logic [3:0]          dec;
   logic [1:0]          best_st;

   function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic u,
                                                input logic [1:0] sym);
      logic [2:0] r;
      logic [1:0] e;
      r = {u, s};
      e = {^(G0 & r), ^(G1 & r)} ^ sym;
      return {1'b0, e[1]} + {1'b0, e[0]};
   endfunction

   function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                   input logic [1:0] b);
      logic [METRIC_W:0] s;
      s = {1'b0, m} + {{(METRIC_W-1){1'b0}}, b};
      return s[METRIC_W] ? M_MAX : s[METRIC_W-1:0];
   endfunction

   assign accept = in_valid && in_ready;
   assign step   = in_sof ? '0 : cnt;

   // A start-of-frame beat runs its ACS on the initial metrics, not on pm.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         base[i] = in_sof ? ((i == 0) ? '0 : M_MAX) : pm[i];
      end
   end

   for (genvar n = 0; n < 4; n++) begin : g_acs
      localparam logic [1:0] N  = 2'(n);
      localparam logic [1:0] P0 = {N[0], 1'b0};
      localparam logic [1:0] P1 = {N[0], 1'b1};
      logic [METRIC_W-1:0] c0, c1;
      assign c0     = sat_add(base[P0], branch_metric(P0, N[1], in_sym));
      assign c1     = sat_add(base[P1], branch_metric(P1, N[1], in_sym));
      assign dec[n] = c1 < c0;
      assign raw[n] = dec[n] ? c1 : c0;
   end

   always_comb begin
      mn = raw[0];
      for (int i = 1; i < 4; i++) begin
         if (raw[i] < mn) mn = raw[i];
      end
      for (int i = 0; i < 4; i++) begin
         norm[i] = raw[i] - mn;
      end
      // Descending scan so the lowest-index zero-metric state is kept.
      best_st = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (norm[i] == '0) best_st = 2'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         st        <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < 4; i++) pm[i] <= '0;
         for (int i = 0; i < FRAME_BITS; i++) surv[i] <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE, ACS: begin
               in_ready <= 1'b1;
               if (accept && (in_sof || state == ACS)) begin
                  for (int i = 0; i < 4; i++) pm[i] <= norm[i];
                  surv[step] <= dec;
                  if (!in_sof && cnt == IW'(FRAME_BITS - 1)) begin
                     state    <= TRACE;
                     in_ready <= 1'b0;
                     cnt      <= IW'(FRAME_BITS - 1);
                     st       <= TERMINATED ? 2'd0 : best_st;
                  end else begin
                     state <= ACS;
                     cnt   <= in_sof ? IW'(1) : cnt + 1'b1;
                  end
               end
            end
            TRACE: begin
               // Bits arrive last-first; shifting in at the MSB lands the first bit there.
               out_data <= {st[1], out_data[FRAME_BITS-1:1]};
               st       <= {st[0], surv[cnt][st]};
               if (cnt == '0) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            OUT: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Bench for viterbi_decoder_k3: an unterminated 8-bit instance and a terminated 10-bit instance
// on shared inputs, checked against an encoder and a register-exchange Viterbi model.
module tb_viterbi_decoder_k3;

   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_sof;
   logic [1:0] in_sym;
   logic       a_ready, a_ovalid, b_ready, b_ovalid;
   logic [7:0] a_data;
   logic [9:0] b_data;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int t_acc  = 0;

   logic [1:0] tx [64];
   logic [1:0] rx [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   viterbi_decoder_k3 #(.FRAME_BITS(8), .G0(G0), .G1(G1), .METRIC_W(5), .TERMINATED(1'b0)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_sym(in_sym),
      .in_ready(a_ready), .out_valid(a_ovalid), .out_data(a_data));

   viterbi_decoder_k3 #(.FRAME_BITS(10), .G0(G0), .G1(G1), .METRIC_W(5), .TERMINATED(1'b1)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_sym(in_sym),
      .in_ready(b_ready), .out_valid(b_ovalid), .out_data(b_data));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void encode(input logic [63:0] d, input int nb);
      logic [1:0] s;
      logic [2:0] r;
      s = 2'b00;
      for (int i = 0; i < nb; i++) begin
         r     = {d[nb-1-i], s};
         tx[i] = {^(G0 & r), ^(G1 & r)};
         s     = {d[nb-1-i], s[1]};
      end
   endfunction

   // Each state carries its whole surviving input sequence instead of survivor bits.
   function automatic logic [63:0] ref_decode(input int nb, input int mw, input bit term);
      int          pm [4];
      int          npm [4];
      logic [63:0] path [4];
      logic [63:0] npath [4];
      int          maxm, best, bp, p, c, mn, es;
      logic [2:0]  r;
      logic [1:0]  e;
      maxm = (1 << mw) - 1;
      pm   = '{0, maxm, maxm, maxm};
      for (int n = 0; n < 4; n++) path[n] = '0;
      for (int i = 0; i < nb; i++) begin
         for (int n = 0; n < 4; n++) begin
            best = 0;
            bp   = 0;
            for (int b = 0; b < 2; b++) begin
               p = (n % 2) * 2 + b;
               r = {1'(n / 2), 2'(p)};
               e = {^(G0 & r), ^(G1 & r)};
               c = pm[p] + int'(e[1] != rx[i][1]) + int'(e[0] != rx[i][0]);
               if (c > maxm) c = maxm;
               if (b == 0 || c < best) begin
                  best = c;
                  bp   = p;
               end
            end
            npm[n]   = best;
            npath[n] = (path[bp] << 1) | 64'(n / 2);
         end
         mn = npm[0];
         for (int n = 1; n < 4; n++) if (npm[n] < mn) mn = npm[n];
         for (int n = 0; n < 4; n++) begin
            pm[n]   = npm[n] - mn;
            path[n] = npath[n];
         end
      end
      es = 0;
      if (!term) for (int n = 3; n >= 0; n--) if (pm[n] == 0) es = n;
      return path[es] & ((64'd1 << nb) - 1);
   endfunction

   task automatic send(input bit sel, input int nb, input int stall_pct, input bit sof_first);
      int w;
      for (int i = 0; i < nb; i++) begin
         while (int'($urandom_range(99)) < stall_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_sym   = rx[i];
         in_sof   = sof_first && (i == 0);
         w = 0;
         while (!(sel ? b_ready : a_ready) && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) check_eq("ready_timeout", 64'(sel ? b_ready : a_ready), 64'd1);
         t_acc = cyc;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic collect(input bit sel, input int nb, input logic [63:0] exp, input string tag);
      int          lo, nv, vc;
      logic        rdy;
      logic [63:0] d;
      lo = 0; nv = 0; vc = 0; d = '0;
      for (int k = 0; k < 60; k++) begin
         rdy = sel ? b_ready : a_ready;
         if (!rdy) lo++;
         if (sel ? b_ovalid : a_ovalid) begin
            nv++;
            vc = cyc;
            d  = sel ? 64'(b_data) : 64'(a_data);
         end
         if (rdy && nv > 0) break;
         @(negedge clk);
      end
      check_eq({tag, "_data"}, d, exp);
      check_eq({tag, "_nvalid"}, 64'(nv), 64'd1);
      check_eq({tag, "_latency"}, 64'(vc - t_acc), 64'(nb + 1));
      check_eq({tag, "_ready_low"}, 64'(lo), 64'(nb + 1));
   endtask

   task automatic load_rx(input int nb);
      for (int i = 0; i < nb; i++) rx[i] = tx[i];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d, exp;
      int          ne, nv;

      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_sym = 2'b00;
      repeat (3) @(negedge clk);
      check_eq("rst_ready_a", 64'(a_ready), 64'd0);
      check_eq("rst_ovalid_a", 64'(a_ovalid), 64'd0);
      check_eq("rst_data_a", 64'(a_data), 64'd0);
      check_eq("rst_data_b", 64'(b_data), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("ready_after_reset", 64'(a_ready), 64'd1);

      encode(64'hB2, 8);
      load_rx(8);
      check_eq("model_clean", ref_decode(8, 5, 0), 64'hB2);
      send(0, 8, 0, 1);
      collect(0, 8, 64'hB2, "clean_b2");

      for (int j = 0; j <= 5; j++) begin
         load_rx(8);
         rx[j][0] = ~rx[j][0];
         send(0, 8, 0, 1);
         collect(0, 8, 64'hB2, $sformatf("err_beat%0d", j));
      end

      encode(64'hFF, 8);
      load_rx(8);
      send(0, 4, 0, 1);
      encode(64'h5A, 8);
      load_rx(8);
      send(0, 8, 0, 1);
      collect(0, 8, 64'h5A, "restart_5a");

      for (int i = 0; i < 3; i++) rx[i] = 2'($urandom_range(3));
      send(0, 3, 0, 0);
      check_eq("drop_ready", 64'(a_ready), 64'd1);
      encode(64'h01, 8);
      load_rx(8);
      send(0, 8, 40, 1);
      collect(0, 8, 64'h01, "stall_01");

      for (int f = 0; f < 24; f++) begin
         d = 64'($urandom_range(255));
         encode(d, 8);
         load_rx(8);
         if (f % 6 == 5) begin
            for (int i = 0; i < 8; i++) rx[i] = 2'($urandom_range(3));
         end else begin
            ne = $urandom_range(3);
            for (int e = 0; e < ne; e++) begin
               int idx;
               idx = $urandom_range(7);
               rx[idx] = rx[idx] ^ 2'($urandom_range(1, 3));
            end
         end
         exp = ref_decode(8, 5, 0);
         send(0, 8, 25, 1);
         collect(0, 8, exp, "rand_a");
      end

      encode(64'hB2, 8);
      load_rx(8);
      send(0, 8, 0, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      for (int k = 0; k < 20; k++) begin
         if (a_ovalid) nv++;
         @(negedge clk);
      end
      check_eq("rst_trace_nvalid", 64'(nv), 64'd0);
      check_eq("rst_trace_data", 64'(a_data), 64'd0);
      load_rx(8);
      send(0, 8, 0, 1);
      collect(0, 8, 64'hB2, "after_rst_b2");

      encode(64'h30C, 10);
      load_rx(10);
      rx[9][0] = ~rx[9][0];
      send(1, 10, 0, 1);
      collect(1, 10, 64'h30C, "term_c3");

      encode(64'h0, 10);
      load_rx(10);
      send(1, 10, 0, 1);
      collect(1, 10, 64'h0, "term_zero");

      for (int f = 0; f < 8; f++) begin
         d = 64'($urandom_range(255)) << 2;
         encode(d, 10);
         load_rx(10);
         if (f % 4 == 3) begin
            for (int i = 0; i < 10; i++) rx[i] = 2'($urandom_range(3));
         end else if ($urandom_range(1) == 1) begin
            int idx;
            idx = $urandom_range(9);
            rx[idx] = rx[idx] ^ 2'($urandom_range(1, 3));
         end
         exp = ref_decode(10, 5, 1);
         send(1, 10, 20, 1);
         collect(1, 10, exp, "rand_b");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
